// File: rtl/dcache_direct_mapped_if.sv
`default_nettype none
// ============================================================================
// dcache_direct_mapped_if : processor D-port and block-memory port of the cache.
// Rev 1.0
// ============================================================================
interface dcache_direct_mapped_if;
  logic         proc_ren;
  logic         proc_wen;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  // slave = the cache, master = pipeline plus main memory
  modport slave (
    input  proc_ren, proc_wen, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output proc_ren, proc_wen, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/dcache_direct_mapped.sv
`default_nettype none
// ============================================================================
// dcache_direct_mapped : direct-mapped write-back/write-allocate D-cache, 4-word
// blocks; define DCACHE_STATS_EN for access/miss counters.   Rev 1.0
// ============================================================================
module dcache_direct_mapped #(
  parameter int NUM_BLOCKS = 8,
  parameter int TAG_W      = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dcache_direct_mapped_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           access_count,
  output logic [31:0]           miss_count
`endif
);
  localparam int IDX_W = $clog2(NUM_BLOCKS);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NUM_BLOCKS-1:0] valid;
  logic [NUM_BLOCKS-1:0] dirty;
  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [127:0]          data_mem [NUM_BLOCKS];

  logic             req;
  logic             hit;
  logic             is_idle;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] addr_tag;
  logic [1:0]       word;
  logic [127:0]     line;

  logic             stall;
  logic             mem_read;
  logic             mem_write;
  logic [27:0]      mem_addr;
  logic [31:0]      rdata;

  assign req      = bus.proc_ren | bus.proc_wen;
  assign word     = bus.proc_addr[1:0];
  assign idx      = bus.proc_addr[IDX_W+1:2];
  assign addr_tag = bus.proc_addr[29:IDX_W+2];
  assign line     = data_mem[idx];
  assign hit      = req && valid[idx] && (tag_mem[idx] == addr_tag);
  assign is_idle  = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = bus.proc_addr[29:2];
    rdata      = '0;
    case (state)
      ST_IDLE: begin
        if (hit) begin
          rdata = line[{word, 5'd0} +: 32];
        end else if (req) begin
          stall      = 1'b1;
          state_next = (valid[idx] && dirty[idx]) ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        stall     = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {tag_mem[idx], idx};
        if (bus.mem_ready) state_next = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.proc_stall = stall;
  assign bus.proc_rdata = rdata;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = line;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        ST_IDLE:      if (hit && bus.proc_wen) dirty[idx] <= 1'b1;
        ST_WRITEBACK: if (bus.mem_ready) dirty[idx] <= 1'b0;
        ST_ALLOCATE: begin
          if (bus.mem_ready) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; valid bits alone decide whether it is used.
  always_ff @(posedge clk) begin
    if (is_idle && hit && bus.proc_wen) begin
      data_mem[idx][{word, 5'd0} +: 32] <= bus.proc_wdata;
    end else if (state == ST_ALLOCATE && bus.mem_ready) begin
      data_mem[idx] <= bus.mem_rdata;
      tag_mem[idx]  <= addr_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      access_count <= '0;
      miss_count   <= '0;
    end else begin
      if (req && !stall)          access_count <= access_count + 32'd1;
      if (is_idle && req && !hit) miss_count   <= miss_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
